sm_regdump_uart: RTL and testbench
==================================

# sm_regdump_uart

Hardware register-dump transmitter for the schoolMIPS debug port. On a `start` pulse it walks `regAddr` through 0..31, captures each `regData` value, and sends one ASCII line per register over a UART TX line. `regAddr` 0 returns the PC; 1..31 return the register file. It sits beside `sm_top` and drives the same `regAddr`/`regData` debug interface, so a board prints the CPU state to a terminal without a simulator.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per UART bit (50 MHz / 115200). Legal values are 2 or more.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a dump. Ignored while `busy`=1.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last stop bit of the dump.
- `regAddr`  out  5  debug read address, driven to `sm_top.regAddr`.
- `regData`  in  32  debug read data from `sm_top`, combinational with `regAddr`.
- `uart_tx`  out  1  serial line: 8N1, LSB first, idles high.

## Operation
- Reset values: `busy`=0, `done`=0, `regAddr`=0, `uart_tx`=1, FSM in IDLE.
- FSM states: IDLE, SETADDR, CAPTURE, SEND, NEXT.
  - IDLE → SETADDR on `start`. This loads the address counter to 0.
  - SETADDR: `regAddr` holds the counter value for one settle cycle, then → CAPTURE.
  - CAPTURE: latch `regData` into a 32-bit snapshot register, reset the character index to 0, then → SEND.
  - SEND: emit 13 characters, one per UART frame:
    - two hex digits of the address;
    - `:` (0x3A);
    - eight hex digits of the snapshot, MS nibble first;
    - CR (0x0D), LF (0x0A).
    - Hex digits are uppercase: 0x30–0x39 for 0–9, 0x41–0x46 for A–F.
    - The address prints as 00..1F.
  - After the 13th frame's stop bit → NEXT.
  - NEXT: if the counter is 31 → IDLE with a `done` pulse. Otherwise increment the counter (5-bit, no wrap reached) and → SETADDR.
- Snapshot rule: `regData` is sampled exactly once per register, in CAPTURE. Changes to `regData` afterwards do not affect the transmitted line.
- A total of 32 lines / 416 bytes is sent per dump.
- A `start` while `busy` is ignored entirely. It is not queued.
- `rst` asserted at any point, including mid-frame:
  - on the next edge all outputs return to their reset values;
  - `uart_tx` goes high immediately (a truncated frame is acceptable);
  - no `done` pulse is produced.
- `start` and `rst` in the same cycle: reset wins.

## Timing
- `start` sampled at edge N:
  - `busy`=1 and `regAddr`=0 from edge N+1;
  - snapshot captured at edge N+2;
  - the first start bit is on `uart_tx` no later than edge N+4.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Within a line, the next start bit begins 1 cycle after the previous stop bit ends. The gap is constant and identical for every byte.
- Between lines: the gap after the LF stop bit is constant, at most 4 cycles (NEXT, SETADDR, CAPTURE, load).
- `done`: asserted for one cycle, 1–2 cycles after the final LF stop bit ends. `busy` falls in the same cycle `done` rises.
- `regAddr` is stable from SETADDR through the end of that register's SEND.

## Structure
- Shared package/header `sm_regdump.vh` holds:
  - character constants (`CH_COLON`, `CH_CR`, `CH_LF`);
  - the line length of 13;
  - FSM state encodings.
- Nibble-to-ASCII conversion is a function in the same header.
- One sub-module, `sm_uart_tx`:
  - parameter `CLKS_PER_BIT`;
  - inputs `clk`, `rst`, `tx_start`, `tx_data[7:0]`;
  - outputs `tx_busy`, `tx`;
  - `tx_busy` is high from the edge that accepts `tx_start` through the end of the stop bit.
- The top FSM issues `tx_start` only when `tx_busy`=0.

## Test plan
- Reset: hold `rst` for 3 cycles, release. Required: `uart_tx`=1, `busy`=0, `done`=0, `regAddr`=0, no line activity for 100 cycles.
- Full dump, `CLKS_PER_BIT`=4, with a model returning 0x00000040 at addr 0 and 0xABCD0000+addr elsewhere. Required:
  - the decoded stream starts `00:00000040\r\n01:ABCD0001\r\n`;
  - it ends `1F:ABCD001F\r\n`;
  - exactly 416 bytes;
  - exactly one `done` pulse.
- Bit timing: measure every bit of the first frame (`0`=0x30). Required: each bit is 4 cycles, LSB first, stop bit high, first start bit ≤ 3 cycles after the `start` edge.
- Snapshot: change `regData` for addr 2 from 0x12345678 to 0xFFFFFFFF mid-line. Required: the line reads `02:12345678`.
- `start` re-asserted at cycle 50 of a dump. Required: no restart, still 416 bytes, one `done`.
- `rst` during the 5th frame. Required: `uart_tx`=1 on the next edge, `busy`=0, no `done`. A new `start` then produces a complete dump from `00:`.

Source files
------------

// File: rtl/sm_regdump_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm_regdump_uart_pkg
// Description : Shared constants, FSM encoding and ASCII helpers for the
//               schoolMIPS register-dump UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package sm_regdump_uart_pkg;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  // "AA:DDDDDDDD\r\n"
  localparam int LINE_LEN = 13;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETADDR = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_NEXT    = 3'd4
  } state_t;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  // Character at position idx of the line for register addr holding data.
  function automatic logic [7:0] line_char(input logic [3:0]  idx,
                                           input logic [4:0]  addr,
                                           input logic [31:0] data);
    logic [2:0] nib_sel;
    logic [7:0] ch;
    // positions 3..10 map to nibbles 7..0 (MS nibble first)
    nib_sel = 3'(4'd10 - idx);
    case (idx)
      4'd0:    ch = nib2ascii({3'b000, addr[4]});
      4'd1:    ch = nib2ascii(addr[3:0]);
      4'd2:    ch = CH_COLON;
      4'd11:   ch = CH_CR;
      4'd12:   ch = CH_LF;
      default: ch = nib2ascii(data[{nib_sel, 2'b00} +: 4]);
    endcase
    return ch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : sm_uart_tx
// Description : 8N1 UART transmitter, LSB first, line idles high.
//               tx_busy covers the accepting edge through end of stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sm_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx
);

  localparam int               C_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(CLKS_PER_BIT - 1);

  logic [C_CNT_W-1:0] r_clk_cnt;
  logic [3:0]         r_bit_idx;   // 0 = start bit, 1..8 = data, 9 = stop
  logic [8:0]         r_shift;     // remaining data bits followed by stop bit

  // Bit timer and shifter; tx is registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy   <= 1'b0;
      tx        <= 1'b1;
      r_clk_cnt <= '0;
      r_bit_idx <= 4'd0;
      r_shift   <= 9'h1FF;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy   <= 1'b1;
        tx        <= 1'b0;
        r_clk_cnt <= '0;
        r_bit_idx <= 4'd0;
        r_shift   <= {1'b1, tx_data};
      end
    end else if (r_clk_cnt == C_CNT_LAST) begin
      r_clk_cnt <= '0;
      if (r_bit_idx == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        r_bit_idx <= r_bit_idx + 4'd1;
        tx        <= r_shift[0];
        r_shift   <= {1'b1, r_shift[8:1]};
      end
    end else begin
      r_clk_cnt <= r_clk_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sm_regdump_uart.sv
`default_nettype none
// ============================================================================
// Module      : sm_regdump_uart
// Description : Walks the schoolMIPS debug port over addresses 0..31 and
//               prints one "AA:DDDDDDDD\r\n" line per register over UART.
// Revision    : 1.0 - initial release
// ============================================================================
module sm_regdump_uart
  import sm_regdump_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        uart_tx
);

  state_t      r_state;
  logic [31:0] r_snap;
  logic [3:0]  r_idx;     // next character position to hand to the UART
  logic        r_last;    // LF already handed over, waiting for its stop bit

  logic        w_tx_busy;
  logic        w_tx_start;
  logic [7:0]  w_tx_data;
  logic [3:0]  w_sel;

  // The address digit does not depend on the snapshot, so the first
  // character is launched already in CAPTURE to keep the line gap short.
  always_comb begin
    w_sel      = (r_state == ST_CAPTURE) ? 4'd0 : r_idx;
    w_tx_data  = line_char(w_sel, regAddr, r_snap);
    w_tx_start = !w_tx_busy &&
                 ((r_state == ST_CAPTURE) || ((r_state == ST_SEND) && !r_last));
  end

  // Dump sequencer with registered busy/done/regAddr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      regAddr <= 5'd0;
      r_snap  <= 32'd0;
      r_idx   <= 4'd0;
      r_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            regAddr <= 5'd0;
            r_state <= ST_SETADDR;
          end
        end
        ST_SETADDR: begin
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_snap  <= regData;
          r_last  <= 1'b0;
          r_idx   <= w_tx_start ? 4'd1 : 4'd0;
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (w_tx_start) begin
            if (r_idx == 4'(LINE_LEN - 1)) r_last <= 1'b1;
            else                            r_idx  <= r_idx + 4'd1;
          end else if (r_last && !w_tx_busy) begin
            r_state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (regAddr == 5'd31) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            regAddr <= regAddr + 5'd1;
            r_state <= ST_SETADDR;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sm_uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_start (w_tx_start),
    .tx_data  (w_tx_data),
    .tx_busy  (w_tx_busy),
    .tx       (uart_tx)
  );

endmodule
`default_nettype wire

// File: tb/tb_sm_regdump_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_regdump_uart
// Description : Directed self-checking bench for sm_regdump_uart with a UART
//               line decoder and a simple debug-port register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_regdump_uart;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  // register model controls
  logic        snap_mode;
  logic [31:0] addr2_val;

  // line decoder state
  logic [7:0]  rx_buf [0:2047];
  int          rx_n        = 0;
  int          frames      = 0;
  int          framing_err = 0;
  int          done_cnt    = 0;
  int          rx_k        = 0;
  logic        rx_active   = 1'b0;
  logic [7:0]  rx_sh       = 8'h00;

  sm_regdump_uart #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .regAddr (regAddr),
    .regData (regData),
    .uart_tx (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // debug-port model: PC at 0, 0xABCD0000+addr elsewhere, addr 2 overridable
  always_comb begin
    if (regAddr == 5'd0)                   regData = 32'h0000_0040;
    else if (snap_mode && regAddr == 5'd2) regData = addr2_val;
    else                                   regData = 32'hABCD_0000 + {27'd0, regAddr};
  end

  // UART decoder sampling mid-bit on the falling clock edge
  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (uart_tx === 1'b0) begin
        rx_active = 1'b1;
        rx_k      = 0;
        frames++;
      end
    end else begin
      rx_k++;
      if (rx_k >= 6 && rx_k <= 34 && ((rx_k - 6) % CPB) == 0)
        rx_sh[(rx_k - 6) / CPB] = uart_tx;
      if (rx_k == 9 * CPB + 2) begin
        if (uart_tx !== 1'b1) framing_err++;
        rx_buf[rx_n] = rx_sh;
        rx_n++;
        rx_active = 1'b0;
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  function automatic string grab(input int from, input int len);
    string s;
    logic [7:0] b;
    s = "";
    for (int i = 0; i < len; i++) begin
      b = rx_buf[from + i];
      if (b == 8'h0D)      s = {s, "<CR>"};
      else if (b == 8'h0A) s = {s, "<LF>"};
      else                 s = {s, $sformatf("%c", b)};
    end
    return s;
  endfunction

  task automatic wait_done(input int d0, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 25000) begin
      @(negedge clk);
      if (done === 1'b1) chk({tag, "_busy_low_at_done"}, busy, 0);
      n++;
    end
    chk({tag, "_done_seen"}, (done_cnt > d0), 1);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  int base, d0, f0, n, idle_bad, gap_hi, gap_lo, expbit;
  int good [10];
  logic [7:0] ch;

  initial begin
    rst = 1'b1; start = 1'b0; snap_mode = 1'b0; addr2_val = 32'h1234_5678;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_regaddr", regAddr, 0);
    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
    end
    chk("idle_quiet", idle_bad, 0);

    // ---------------- dump A: timing, re-start, full stream ----------------
    base = rx_n; d0 = done_cnt;
    pulse_start();
    // now half a cycle after the edge that sampled start
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("regaddr_after_start", regAddr, 0);
    n = 1;
    while (uart_tx !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("first_start_bit_latency_le3", (n <= 3), 1);

    ch = 8'h30;
    for (int b = 0; b < 10; b++) good[b] = 0;
    gap_hi = 0; gap_lo = 1;
    for (int k = 0; k < 42; k++) begin
      if (k < 40) begin
        if (k / CPB == 0)      expbit = 0;
        else if (k / CPB == 9) expbit = 1;
        else                   expbit = int'(ch[k / CPB - 1]);
        if (uart_tx === 1'(expbit)) good[k / CPB]++;
      end else if (k == 40) begin
        gap_hi = int'(uart_tx);
      end else begin
        gap_lo = int'(uart_tx);
      end
      @(negedge clk);
    end
    for (int b = 0; b < 10; b++) chk($sformatf("frame0_bit%0d_cycles", b), good[b], CPB);
    chk("intra_line_gap_high", gap_hi, 1);
    chk("next_start_after_gap", gap_lo, 0);

    repeat (50 - (n + 42)) @(negedge clk);
    pulse_start();
    chk("busy_kept_on_restart", busy, 1);

    wait_done(d0, "dumpA");
    repeat (60) @(negedge clk);
    chk("dumpA_bytes", rx_n - base, 416);
    chk("dumpA_done_pulses", done_cnt - d0, 1);
    chk_str("dumpA_head", grab(base, 26), "00:00000040<CR><LF>01:ABCD0001<CR><LF>");
    chk_str("dumpA_tail", grab(base + 403, 13), "1F:ABCD001F<CR><LF>");

    // ---------------- dump B: reset during the 5th frame ----------------
    f0 = frames; d0 = done_cnt;
    pulse_start();
    n = 0;
    while (frames < f0 + 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("fifth_frame_started", (frames >= f0 + 5), 1);
    repeat (10) @(negedge clk);
    chk("tx_low_before_rst", uart_tx, 0);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("midrst_uart_tx", uart_tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_regaddr", regAddr, 0);
    rst = 1'b0; start = 1'b0;
    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) idle_bad++;
    end
    chk("post_rst_quiet", idle_bad, 0);
    chk("rst_no_done", done_cnt - d0, 0);

    // ---------------- dump C: complete dump, snapshot on addr 2 ----------------
    snap_mode = 1'b1;
    base = rx_n; d0 = done_cnt;
    pulse_start();
    n = 0;
    while (rx_n < base + 30 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_line2", (rx_n >= base + 30), 1);
    chk("regaddr_on_line2", regAddr, 2);
    addr2_val = 32'hFFFF_FFFF;
    wait_done(d0, "dumpC");
    repeat (60) @(negedge clk);
    chk("dumpC_bytes", rx_n - base, 416);
    chk("dumpC_done_pulses", done_cnt - d0, 1);
    chk_str("dumpC_head", grab(base, 13), "00:00000040<CR><LF>");
    chk_str("dumpC_snapshot_line2", grab(base + 26, 13), "02:12345678<CR><LF>");
    chk_str("dumpC_tail", grab(base + 403, 13), "1F:ABCD001F<CR><LF>");
    chk("stop_bits_high", framing_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
